// File: rtl/fifo_checker.sv
// Passive on-line checker for a valid/ready-in, valid/yumi-out FIFO.
// Shadows the FIFO in a reference queue and flags reset, data and protocol errors, with occupancy coverage.
module fifo_checker #(
    parameter int width_p = 8,
    parameter int cap_p   = 8,
    parameter int cnt_w_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_i,
    input  logic [width_p-1:0] mon_data_i,
    input  logic               mon_valid_i,
    input  logic               mon_ready_i,
    input  logic [width_p-1:0] mon_data_o,
    input  logic               mon_valid_o,
    input  logic               mon_yumi_i,
    output logic [cap_p-1:0]   enq_cov_o,
    output logic [cap_p-1:0]   deq_cov_o,
    output logic [cap_p-2:0]   both_cov_o,
    output logic               res_err_o,
    output logic               data_err_o,
    output logic               proto_err_o,
    output logic [cnt_w_p-1:0] err_cnt_o,
    output logic [width_p-1:0] first_err_o
);
    localparam int ptr_w = $clog2(cap_p);
    localparam int occ_w = $clog2(cap_p + 1);

    logic [cap_p-1:0][width_p-1:0] mem;
    logic [ptr_w-1:0]   rd_ptr, wr_ptr;
    logic [occ_w-1:0]   occ;
    logic               post_rst;
    logic               first_vld;

    logic               full, empty, enq, deq;
    logic               enq_only, deq_only, both;
    logic [width_p-1:0] head;
    logic               res_nxt, data_nxt, proto_nxt;
    logic [1:0]         inc;
    logic [cnt_w_p:0]   cnt_sum;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(cap_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    always_comb begin
        full     = (occ == occ_w'(cap_p));
        empty    = (occ == '0);
        head     = mem[rd_ptr];
        // Model never overflows or underflows even if the FIFO misbehaves.
        enq      = mon_valid_i & mon_ready_i & ~full;
        deq      = mon_yumi_i & mon_valid_o & ~empty;
        enq_only = enq & ~deq;
        deq_only = deq & ~enq;
        both     = enq & deq;
        res_nxt   = post_rst & ~(mon_ready_i & ~mon_valid_o);
        data_nxt  = ~post_rst & ((mon_valid_o != ~empty) | (~empty & (mon_data_o != head)));
        proto_nxt = ~post_rst & ((mon_yumi_i & ~mon_valid_o) | (mon_ready_i & full));
        inc       = 2'(res_nxt) + 2'(data_nxt) + 2'(proto_nxt);
        cnt_sum   = {1'b0, err_cnt_o} + (cnt_w_p + 1)'(inc);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            post_rst    <= 1'b1;
            res_err_o   <= 1'b0;
            data_err_o  <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            post_rst    <= 1'b0;
            res_err_o   <= res_nxt;
            data_err_o  <= data_nxt;
            proto_err_o <= proto_nxt;
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            if (enq_only)      occ <= occ + occ_w'(1);
            else if (deq_only) occ <= occ - occ_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && enq) mem[wr_ptr] <= mon_data_i;
    end

    // Coverage, counter and first-error capture survive reset; only clr_i clears them.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            enq_cov_o   <= '0;
            deq_cov_o   <= '0;
            both_cov_o  <= '0;
            err_cnt_o   <= '0;
            first_err_o <= '0;
            first_vld   <= 1'b0;
        end else if (reset_n_i) begin
            for (int i = 0; i < cap_p; i++) begin
                if (enq_only && occ == occ_w'(i))     enq_cov_o[i] <= 1'b1;
                if (deq_only && occ == occ_w'(i + 1)) deq_cov_o[i] <= 1'b1;
            end
            for (int i = 0; i < cap_p - 1; i++) begin
                if (both && occ == occ_w'(i + 1)) both_cov_o[i] <= 1'b1;
            end
            err_cnt_o <= cnt_sum[cnt_w_p] ? '1 : cnt_sum[cnt_w_p-1:0];
            if (data_nxt && !first_vld) begin
                first_err_o <= head;
                first_vld   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench for fifo_checker: a small queue stands in for a correct FIFO; faults are driven by hand.
module tb_fifo_checker;
    localparam int W = 8, CAP = 8, CW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic clr = 1'b0;
    logic mon_valid_i = 1'b0, mon_ready_i = 1'b1, mon_valid_o = 1'b0, mon_yumi_i = 1'b0;
    logic [W-1:0] mon_data_i = '0, mon_data_o = '0;
    logic [CAP-1:0] enq_cov, deq_cov;
    logic [CAP-2:0] both_cov;
    logic res_err, data_err, proto_err;
    logic [CW-1:0] err_cnt;
    logic [W-1:0] first_err;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] fq[$];

    fifo_checker #(.width_p(W), .cap_p(CAP), .cnt_w_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .clr_i(clr),
        .mon_data_i(mon_data_i), .mon_valid_i(mon_valid_i), .mon_ready_i(mon_ready_i),
        .mon_data_o(mon_data_o), .mon_valid_o(mon_valid_o), .mon_yumi_i(mon_yumi_i),
        .enq_cov_o(enq_cov), .deq_cov_o(deq_cov), .both_cov_o(both_cov),
        .res_err_o(res_err), .data_err_o(data_err), .proto_err_o(proto_err),
        .err_cnt_o(err_cnt), .first_err_o(first_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of a well-behaved FIFO: ready/valid_o/data_o follow the bench queue.
    task automatic cyc(input logic vi, input logic [W-1:0] di, input logic yi);
        logic do_push, do_pop;
        mon_valid_i = vi;
        mon_data_i  = di;
        mon_yumi_i  = yi;
        mon_ready_i = (fq.size() < CAP);
        mon_valid_o = (fq.size() != 0);
        mon_data_o  = (fq.size() != 0) ? fq[0] : '0;
        do_push = vi && (fq.size() < CAP);
        do_pop  = yi && (fq.size() != 0);
        tick();
        if (do_pop) void'(fq.pop_front());
        if (do_push) fq.push_back(di);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc(1'b0, '0, 1'b0);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        mon_valid_i = 0; mon_ready_i = 1; mon_valid_o = 0; mon_yumi_i = 0;
        clr = 1'b1;
        #2 reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if ({res_err, data_err, proto_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {res_err, data_err, proto_err}); end
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", err_cnt); end
        checks++; if ({enq_cov, deq_cov, both_cov} !== '0) begin errors++; $display("FAIL reset_cov got %h %h %h want 0", enq_cov, deq_cov, both_cov); end
        cyc(1'b0, '0, 1'b0);
        checks++; if ({res_err, data_err, proto_err} !== 3'b000) begin errors++; $display("FAIL reset_idle got %b want 000", {res_err, data_err, proto_err}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < CAP; i++) cyc(1'b1, W'(8'h10 + i), 1'b0);
        checks++; if (enq_cov !== 8'hFF) begin errors++; $display("FAIL fill_enq_cov got %h want ff", enq_cov); end
        for (int i = 0; i < CAP; i++) begin
            cyc(1'b0, '0, 1'b1);
            checks++; if ({res_err, data_err, proto_err} !== 3'b000) begin errors++; $display("FAIL drain_pulses step %0d got %b want 000", i, {res_err, data_err, proto_err}); end
        end
        checks++; if (deq_cov !== 8'hFF) begin errors++; $display("FAIL drain_deq_cov got %h want ff", deq_cov); end
        checks++; if (both_cov !== 7'h00) begin errors++; $display("FAIL drain_both_cov got %h want 00", both_cov); end
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL drain_cnt got %h want 0", err_cnt); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        for (int i = 0; i < 7; i++) cyc(1'b1, W'(8'h20 + i), 1'b0);
        cyc(1'b1, 8'h30, 1'b1);
        checks++; if (both_cov !== 7'h40) begin errors++; $display("FAIL b2b_both_occ7 got %h want 40", both_cov); end
        checks++; if (enq_cov !== 8'h7F) begin errors++; $display("FAIL b2b_enq_untouched got %h want 7f", enq_cov); end
        checks++; if (deq_cov !== 8'h00) begin errors++; $display("FAIL b2b_deq_untouched got %h want 00", deq_cov); end
        for (int k = 6; k >= 1; k--) begin
            cyc(1'b0, '0, 1'b1);
            cyc(1'b1, W'(8'h40 + k), 1'b1);
        end
        checks++; if (both_cov !== 7'h7F) begin errors++; $display("FAIL b2b_both got %h want 7f", both_cov); end
        checks++; if (deq_cov !== 8'h7E) begin errors++; $display("FAIL b2b_deq got %h want 7e", deq_cov); end
        cyc(1'b0, '0, 1'b1);
        checks++; if (deq_cov !== 8'h7F) begin errors++; $display("FAIL b2b_last_deq got %h want 7f", deq_cov); end
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL b2b_cnt got %h want 0", err_cnt); end
    endtask

    task automatic test_data_err();
        do_clr();
        cyc(1'b1, 8'hA5, 1'b0);
        mon_valid_i = 0; mon_yumi_i = 0; mon_ready_i = 1; mon_valid_o = 1; mon_data_o = 8'h5A;
        tick();
        checks++; if (data_err !== 1'b1) begin errors++; $display("FAIL data_err got %b want 1", data_err); end
        checks++; if (first_err !== 8'hA5) begin errors++; $display("FAIL data_first got %h want a5", first_err); end
        checks++; if (err_cnt !== 4'h1) begin errors++; $display("FAIL data_cnt got %h want 1", err_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL data_proto got %b want 0", proto_err); end
        cyc(1'b0, '0, 1'b1);
        checks++; if (data_err !== 1'b0) begin errors++; $display("FAIL data_deassert got %b want 0", data_err); end
        cyc(1'b1, 8'h33, 1'b0);
        mon_valid_o = 1; mon_data_o = 8'h00;
        tick();
        checks++; if (data_err !== 1'b1) begin errors++; $display("FAIL data_err2 got %b want 1", data_err); end
        checks++; if (first_err !== 8'hA5) begin errors++; $display("FAIL data_first_held got %h want a5", first_err); end
        cyc(1'b0, '0, 1'b1);
        checks++; if (err_cnt !== 4'h2) begin errors++; $display("FAIL data_cnt2 got %h want 2", err_cnt); end
    endtask

    task automatic test_reset_err();
        do_clr();
        mon_valid_i = 0; mon_yumi_i = 0; mon_ready_i = 0; mon_valid_o = 0;
        reset_n = 1'b0;
        fq.delete();
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL res_err got %b want 1", res_err); end
        checks++; if (err_cnt !== 4'h1) begin errors++; $display("FAIL res_cnt got %h want 1", err_cnt); end
        cyc(1'b0, '0, 1'b0);
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL res_deassert got %b want 0", res_err); end
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'h61 + i), 1'b0);
        checks++; if (enq_cov !== 8'h07) begin errors++; $display("FAIL mid_enq_cov got %h want 07", enq_cov); end
        mon_valid_i = 0; mon_ready_i = 1; mon_valid_o = 0;
        reset_n = 1'b0;
        fq.delete();
        tick();
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b0);
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL mid_res got %b want 0", res_err); end
        checks++; if (enq_cov !== 8'h07) begin errors++; $display("FAIL mid_cov_kept got %h want 07", enq_cov); end
        cyc(1'b0, '0, 1'b0);
        checks++; if (data_err !== 1'b0) begin errors++; $display("FAIL mid_occ0 got %b want 0", data_err); end
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, '0, 1'b1);
        checks++; if (data_err !== 1'b0) begin errors++; $display("FAIL mid_head got %b want 0", data_err); end
        checks++; if (deq_cov !== 8'h01) begin errors++; $display("FAIL mid_deq_cov got %h want 01", deq_cov); end
        checks++; if (err_cnt !== 4'h1) begin errors++; $display("FAIL mid_cnt got %h want 1", err_cnt); end
    endtask

    task automatic test_proto_sat();
        do_clr();
        checks++; if (first_err !== 8'h00) begin errors++; $display("FAIL clr_first got %h want 00", first_err); end
        mon_valid_i = 0; mon_ready_i = 1; mon_valid_o = 0; mon_yumi_i = 1;
        tick();
        checks++; if ({proto_err, data_err} !== 2'b10) begin errors++; $display("FAIL proto_yumi got %b want 10", {proto_err, data_err}); end
        mon_yumi_i = 0;
        tick();
        checks++; if ({proto_err, data_err} !== 2'b00) begin errors++; $display("FAIL proto_occ_kept got %b want 00", {proto_err, data_err}); end
        for (int i = 0; i < CAP; i++) cyc(1'b1, W'(8'h80 + i), 1'b0);
        mon_valid_i = 1; mon_data_i = 8'h99; mon_ready_i = 1; mon_valid_o = 1; mon_data_o = fq[0]; mon_yumi_i = 0;
        tick();
        checks++; if ({proto_err, data_err} !== 2'b10) begin errors++; $display("FAIL proto_full got %b want 10", {proto_err, data_err}); end
        for (int i = 0; i < CAP; i++) cyc(1'b0, '0, 1'b1);
        checks++; if (err_cnt !== 4'h2) begin errors++; $display("FAIL proto_no_overwrite got %h want 2", err_cnt); end
        // clr in the same cycle as an error still leaves the counter at zero
        clr = 1; mon_valid_i = 0; mon_ready_i = 1; mon_valid_o = 0; mon_yumi_i = 1;
        tick();
        clr = 0;
        checks++; if (err_cnt !== 4'h0) begin errors++; $display("FAIL clr_wins got %h want 0", err_cnt); end
        for (int i = 0; i < 14; i++) tick();
        checks++; if (err_cnt !== 4'hE) begin errors++; $display("FAIL sat_14 got %h want e", err_cnt); end
        tick();
        checks++; if (err_cnt !== 4'hF) begin errors++; $display("FAIL sat_15 got %h want f", err_cnt); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (err_cnt !== 4'hF) begin errors++; $display("FAIL sat_21 got %h want f", err_cnt); end
        mon_yumi_i = 0;
        tick();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL sat_deassert got %b want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_data_err();
        test_reset_err();
        test_proto_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end
endmodule
